pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Successor to the single-cycle combinational ARM decode control.
- Decodes mode, opcode, S, I and cond for one instruction per cycle in ID.
- Registers the resulting control bundle through ID/EX, EX/MEM and MEM/WB stage registers.
- Supports hazard bubbles, branch flush and a global memory freeze.
- Exposes per-stage destination and writeback info to the hazard/forwarding unit.

Parameters:
- MODE_W, 2, instruction mode field width
- OPCODE_W, 4, opcode field width
- EXEC_CMD_W, 4, ALU execute command width
- REG_ADDR_W, 4, register address width (Rd)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- mode  in  MODE_W  instruction mode field
- opcode  in  OPCODE_W  instruction opcode field
- s  in  1  S bit (set flags; for memory mode: 1=LDR, 0=STR)
- imm  in  1  I bit
- cond  in  4  ARM condition field
- status  in  4  NZCV from status register
- rd  in  REG_ADDR_W  destination register
- hazard  in  1  insert bubble into ID/EX
- flush  in  1  branch taken in EX; kill ID instruction
- freeze  in  1  memory wait; hold all stage registers
- ex_valid, ex_cmd[EXEC_CMD_W], ex_mem_read, ex_mem_write, ex_wb_en, ex_imm, ex_branch, ex_status_we, ex_rd[REG_ADDR_W]  out  EX-stage control
- mem_valid, mem_read, mem_write, mem_wb_en, mem_rd  out  MEM-stage control
- wb_valid, wb_en, wb_mem_to_reg, wb_rd  out  WB-stage control
- id_cond_pass  out  1  combinational condition result for ID

Behaviour:
- Reset (rst_n=0 at posedge): every registered output is 0. id_cond_pass remains combinational.
- Decode, combinational. Mode 00 (arithmetic): cmd for MOV 1101 is 0001, MVN 1111 is 1001, ADD 0100 is 0010, ADC 0101 is 0011, SUB 0010 is 0100, SBC 0110 is 0101, AND 0000 is 0110, ORR 1100 is 0111, EOR 0001 is 1000, CMP 1010 is 0100, TST 1000 is 0110.
- Mode 00 flags: wb_en=1 except CMP/TST; status_we=s; imm=I. Unlisted opcode decodes as a no-op (all control 0, valid kept).
- Mode 01 (memory), opcode 0100: cmd=0010, imm=1. s=1 gives LDR (mem_read=1, wb_en=1). s=0 gives STR (mem_write=1). Other opcodes decode as a no-op.
- Mode 10: branch=1, all else 0. Mode 11: no-op.
- Condition pass is evaluated on NZCV per ARM codes 0000–1110. 1111 always fails.
- Bubble: valid=0 and all control 0. rd is don't-care but is driven 0.
- Per-edge priority, applied when rst_n=1:
  - freeze=1: all three stages hold.
  - else flush=1 or hazard=1 or id_valid=0 or cond fails: ID/EX loads a bubble.
  - else ID/EX loads the decode.
  - Whenever not frozen, EX/MEM takes from ID/EX and MEM/WB takes from EX/MEM.
- wb_mem_to_reg = registered mem_read.
- Latency: the decode appears on ex_* one cycle after capture, mem_* after two, wb_* after three.
- Simultaneous flush+hazard acts as a single bubble. A branch in EX does not self-kill.
- Reset mid-stream clears all stages, including any in-flight store.

Optional Feature:
- COND_CHECK_EN: when defined, the condition result gates ID/EX load as above.
- When undefined, every valid instruction executes regardless of cond, and id_cond_pass is tied to 1.

Decomposition:
- Package arm_ctrl_pkg holds:
  - mode constants ARITH/MEM/BRANCH
  - opcode constants
  - execute-command constants
  - condition codes
  - a packed struct for the control bundle (valid, cmd, mem_read, mem_write, wb_en, imm, branch, status_we, rd)
- Sub-module ctrl_decoder: the pure combinational decode plus condition check. The top holds the three stage registers and the priority logic.

Test Plan:
- ADD r3 (mode 00, opcode 0100, s=1, cond 1110), id_valid=1 -> next cycle ex_cmd=0010, ex_wb_en=1, ex_status_we=1, ex_rd=3. mem_wb_en=1 at +2. wb_en=1, wb_rd=3 at +3.
- LDR r5 (mode 01, opcode 0100, s=1) -> ex_mem_read=1, ex_cmd=0010, ex_imm=1. wb_mem_to_reg=1, wb_rd=5 at +3. STR variant gives mem_write=1, wb_en=0 throughout.
- hazard=1 with ADD in ID -> ex_valid=0 with all control 0. The prior instruction still advances to MEM.
- freeze=1 for 2 cycles with instructions in all stages -> all outputs unchanged for 2 cycles, then resume in order.
- With COND_CHECK_EN: cond=0000 (EQ) and status Z=0 -> bubble in EX. With Z=1 -> instruction executes. Without the macro, both cases execute.
- rst_n=0 for one cycle with a pipeline full of STR -> all valid, mem_write and wb_en are 0 the next cycle.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_ctrl_pkg
// Description : Shared definitions for the pipelined ARM control unit.
//               Field widths, mode/opcode/execute-command/condition
//               constants, the per-stage control bundles and the
//               condition-evaluation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_ctrl_pkg;

  localparam int MODE_BITS   = 2;
  localparam int OPCODE_BITS = 4;
  localparam int CMD_BITS    = 4;
  localparam int RD_BITS     = 4;

  // Instruction modes
  localparam logic [MODE_BITS-1:0] c_MODE_ARITH  = 2'b00;
  localparam logic [MODE_BITS-1:0] c_MODE_MEM    = 2'b01;
  localparam logic [MODE_BITS-1:0] c_MODE_BRANCH = 2'b10;

  // Opcodes
  localparam logic [OPCODE_BITS-1:0] c_OP_AND = 4'b0000;
  localparam logic [OPCODE_BITS-1:0] c_OP_EOR = 4'b0001;
  localparam logic [OPCODE_BITS-1:0] c_OP_SUB = 4'b0010;
  localparam logic [OPCODE_BITS-1:0] c_OP_ADD = 4'b0100;
  localparam logic [OPCODE_BITS-1:0] c_OP_ADC = 4'b0101;
  localparam logic [OPCODE_BITS-1:0] c_OP_SBC = 4'b0110;
  localparam logic [OPCODE_BITS-1:0] c_OP_TST = 4'b1000;
  localparam logic [OPCODE_BITS-1:0] c_OP_CMP = 4'b1010;
  localparam logic [OPCODE_BITS-1:0] c_OP_ORR = 4'b1100;
  localparam logic [OPCODE_BITS-1:0] c_OP_MOV = 4'b1101;
  localparam logic [OPCODE_BITS-1:0] c_OP_MVN = 4'b1111;
  // Memory instructions use the ADD opcode for address generation
  localparam logic [OPCODE_BITS-1:0] c_OP_LDST = 4'b0100;

  // Execute commands
  localparam logic [CMD_BITS-1:0] c_EXE_NOP = 4'b0000;
  localparam logic [CMD_BITS-1:0] c_EXE_MOV = 4'b0001;
  localparam logic [CMD_BITS-1:0] c_EXE_ADD = 4'b0010;
  localparam logic [CMD_BITS-1:0] c_EXE_ADC = 4'b0011;
  localparam logic [CMD_BITS-1:0] c_EXE_SUB = 4'b0100;
  localparam logic [CMD_BITS-1:0] c_EXE_SBC = 4'b0101;
  localparam logic [CMD_BITS-1:0] c_EXE_AND = 4'b0110;
  localparam logic [CMD_BITS-1:0] c_EXE_ORR = 4'b0111;
  localparam logic [CMD_BITS-1:0] c_EXE_EOR = 4'b1000;
  localparam logic [CMD_BITS-1:0] c_EXE_MVN = 4'b1001;

  // Condition codes
  localparam logic [3:0] c_COND_EQ = 4'b0000;
  localparam logic [3:0] c_COND_NE = 4'b0001;
  localparam logic [3:0] c_COND_CS = 4'b0010;
  localparam logic [3:0] c_COND_CC = 4'b0011;
  localparam logic [3:0] c_COND_MI = 4'b0100;
  localparam logic [3:0] c_COND_PL = 4'b0101;
  localparam logic [3:0] c_COND_VS = 4'b0110;
  localparam logic [3:0] c_COND_VC = 4'b0111;
  localparam logic [3:0] c_COND_HI = 4'b1000;
  localparam logic [3:0] c_COND_LS = 4'b1001;
  localparam logic [3:0] c_COND_GE = 4'b1010;
  localparam logic [3:0] c_COND_LT = 4'b1011;
  localparam logic [3:0] c_COND_GT = 4'b1100;
  localparam logic [3:0] c_COND_LE = 4'b1101;
  localparam logic [3:0] c_COND_AL = 4'b1110;

  // Full control bundle held in ID/EX
  typedef struct packed {
    logic                valid;
    logic [CMD_BITS-1:0] cmd;
    logic                mem_read;
    logic                mem_write;
    logic                wb_en;
    logic                imm;
    logic                branch;
    logic                status_we;
    logic [RD_BITS-1:0]  rd;
  } ctrl_t;

  // Subset still needed in MEM
  typedef struct packed {
    logic               valid;
    logic               mem_read;
    logic               mem_write;
    logic               wb_en;
    logic [RD_BITS-1:0] rd;
  } mem_ctrl_t;

  // Subset still needed in WB; mem_read becomes mem_to_reg here
  typedef struct packed {
    logic               valid;
    logic               wb_en;
    logic               mem_read;
    logic [RD_BITS-1:0] rd;
  } wb_ctrl_t;

  // ARM condition evaluation; nzcv = {N, Z, C, V}. Code 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      c_COND_EQ: cond_pass = z;
      c_COND_NE: cond_pass = !z;
      c_COND_CS: cond_pass = c;
      c_COND_CC: cond_pass = !c;
      c_COND_MI: cond_pass = n;
      c_COND_PL: cond_pass = !n;
      c_COND_VS: cond_pass = v;
      c_COND_VC: cond_pass = !v;
      c_COND_HI: cond_pass = c && !z;
      c_COND_LS: cond_pass = !c || z;
      c_COND_GE: cond_pass = (n == v);
      c_COND_LT: cond_pass = (n != v);
      c_COND_GT: cond_pass = !z && (n == v);
      c_COND_LE: cond_pass = z || (n != v);
      c_COND_AL: cond_pass = 1'b1;
      default:   cond_pass = 1'b0;
    endcase
  endfunction

endpackage : arm_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decoder
// Description : Pure combinational ARM decode for the ID stage plus the
//               condition check. Unrecognised encodings decode as a no-op
//               (valid kept, all control 0).
// Ports       : mode_i/opcode_i/s_i/imm_i/rd_i - instruction fields
//               cond_i/status_i                - condition field and NZCV
//               ctrl_o                         - decoded control bundle
//               cond_pass_o                    - condition result
// Config      : COND_CHECK_EN - when undefined cond_pass_o is tied to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decoder
  import arm_ctrl_pkg::*;
(
  input  logic [MODE_BITS-1:0]   mode_i,
  input  logic [OPCODE_BITS-1:0] opcode_i,
  input  logic                   s_i,
  input  logic                   imm_i,
  input  logic [3:0]             cond_i,
  input  logic [3:0]             status_i,
  input  logic [RD_BITS-1:0]     rd_i,
  output ctrl_t                  ctrl_o,
  output logic                   cond_pass_o
);

  logic w_arith_known;

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.valid  = 1'b1;
    ctrl_o.rd     = rd_i;
    w_arith_known = 1'b1;
    case (mode_i)
      c_MODE_ARITH: begin
        case (opcode_i)
          c_OP_MOV: ctrl_o.cmd = c_EXE_MOV;
          c_OP_MVN: ctrl_o.cmd = c_EXE_MVN;
          c_OP_ADD: ctrl_o.cmd = c_EXE_ADD;
          c_OP_ADC: ctrl_o.cmd = c_EXE_ADC;
          c_OP_SUB: ctrl_o.cmd = c_EXE_SUB;
          c_OP_SBC: ctrl_o.cmd = c_EXE_SBC;
          c_OP_AND: ctrl_o.cmd = c_EXE_AND;
          c_OP_ORR: ctrl_o.cmd = c_EXE_ORR;
          c_OP_EOR: ctrl_o.cmd = c_EXE_EOR;
          c_OP_CMP: ctrl_o.cmd = c_EXE_SUB;
          c_OP_TST: ctrl_o.cmd = c_EXE_AND;
          default:  w_arith_known = 1'b0;
        endcase
        if (w_arith_known) begin
          // CMP/TST only update flags, never the register file
          ctrl_o.wb_en     = !((opcode_i == c_OP_CMP) || (opcode_i == c_OP_TST));
          ctrl_o.status_we = s_i;
          ctrl_o.imm       = imm_i;
        end
      end
      c_MODE_MEM: begin
        if (opcode_i == c_OP_LDST) begin
          ctrl_o.cmd       = c_EXE_ADD;
          ctrl_o.imm       = 1'b1;
          // S distinguishes load (1) from store (0)
          ctrl_o.mem_read  = s_i;
          ctrl_o.wb_en     = s_i;
          ctrl_o.mem_write = !s_i;
        end
      end
      c_MODE_BRANCH: ctrl_o.branch = 1'b1;
      default: ;
    endcase
  end

`ifdef COND_CHECK_EN
  assign cond_pass_o = cond_pass(cond_i, status_i);
`else
  logic w_unused_cond;
  assign w_unused_cond = ^{cond_i, status_i};
  assign cond_pass_o   = 1'b1;
`endif

endmodule : ctrl_decoder
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit
// Description : ID-stage decode registered through ID/EX, EX/MEM and
//               MEM/WB. Supports bubbles (hazard / flush / invalid / failed
//               condition) and a global freeze that holds every stage.
// Ports       : clk, rst_n (sync, active low)
//               id_valid, mode, opcode, s, imm, cond, status, rd - ID inputs
//               hazard, flush, freeze                         - pipeline control
//               ex_*  - EX-stage control,  mem_* - MEM-stage control
//               wb_*  - WB-stage control,  id_cond_pass - ID condition result
// Config      : COND_CHECK_EN - a failing condition turns ID into a bubble;
//               undefined, every valid instruction executes.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int MODE_W     = MODE_BITS,
  parameter int OPCODE_W   = OPCODE_BITS,
  parameter int EXEC_CMD_W = CMD_BITS,
  parameter int REG_ADDR_W = RD_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [MODE_W-1:0]     mode,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  s,
  input  logic                  imm,
  input  logic [3:0]            cond,
  input  logic [3:0]            status,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic                  freeze,
  output logic                  ex_valid,
  output logic [EXEC_CMD_W-1:0] ex_cmd,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_wb_en,
  output logic                  ex_imm,
  output logic                  ex_branch,
  output logic                  ex_status_we,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_wb_en,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_en,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  id_cond_pass
);

  ctrl_t     w_dec;
  ctrl_t     idex_d,  idex_q;
  mem_ctrl_t exmem_d, exmem_q;
  wb_ctrl_t  memwb_d, memwb_q;

  ctrl_decoder u_decoder (
    .mode_i      (mode),
    .opcode_i    (opcode),
    .s_i         (s),
    .imm_i       (imm),
    .cond_i      (cond),
    .status_i    (status),
    .rd_i        (rd),
    .ctrl_o      (w_dec),
    .cond_pass_o (id_cond_pass)
  );

  // Flush and hazard both collapse into one bubble; the EX-stage branch that
  // raised flush has already left ID/EX so it advances untouched.
  always_comb begin
    if (flush || hazard || !id_valid || !id_cond_pass) idex_d = '0;
    else                                               idex_d = w_dec;

    exmem_d.valid     = idex_q.valid;
    exmem_d.mem_read  = idex_q.mem_read;
    exmem_d.mem_write = idex_q.mem_write;
    exmem_d.wb_en     = idex_q.wb_en;
    exmem_d.rd        = idex_q.rd;

    memwb_d.valid     = exmem_q.valid;
    memwb_d.wb_en     = exmem_q.wb_en;
    memwb_d.mem_read  = exmem_q.mem_read;
    memwb_d.rd        = exmem_q.rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (!freeze) begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_valid      = idex_q.valid;
  assign ex_cmd        = idex_q.cmd;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_wb_en      = idex_q.wb_en;
  assign ex_imm        = idex_q.imm;
  assign ex_branch     = idex_q.branch;
  assign ex_status_we  = idex_q.status_we;
  assign ex_rd         = idex_q.rd;

  assign mem_valid     = exmem_q.valid;
  assign mem_read      = exmem_q.mem_read;
  assign mem_write     = exmem_q.mem_write;
  assign mem_wb_en     = exmem_q.wb_en;
  assign mem_rd        = exmem_q.rd;

  assign wb_valid      = memwb_q.valid;
  assign wb_en         = memwb_q.wb_en;
  assign wb_mem_to_reg = memwb_q.mem_read;
  assign wb_rd         = memwb_q.rd;

endmodule : pipelined_control_unit
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_control_unit
// Description : Directed-vector bench for pipelined_control_unit with
//               hand-computed expectations. Honours COND_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s, imm;
  logic [3:0] cond, status, rd;
  logic       hazard, flush, freeze;
  logic       ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_imm, ex_branch, ex_status_we;
  logic [3:0] ex_cmd, ex_rd;
  logic       mem_valid, mem_read, mem_write, mem_wb_en;
  logic [3:0] mem_rd;
  logic       wb_valid, wb_en, wb_mem_to_reg;
  logic [3:0] wb_rd;
  logic       id_cond_pass;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef COND_CHECK_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  pipelined_control_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .mode(mode), .opcode(opcode),
    .s(s), .imm(imm), .cond(cond), .status(status), .rd(rd),
    .hazard(hazard), .flush(flush), .freeze(freeze),
    .ex_valid(ex_valid), .ex_cmd(ex_cmd), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en), .ex_imm(ex_imm),
    .ex_branch(ex_branch), .ex_status_we(ex_status_we), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wb_en(mem_wb_en), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .id_cond_pass(id_cond_pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] m, input logic [3:0] op, input logic sb,
                     input logic ib, input logic [3:0] r);
    id_valid = 1'b1; mode = m; opcode = op; s = sb; imm = ib; rd = r; cond = 4'b1110;
  endtask

  task automatic idle();
    id_valid = 1'b0; mode = 2'b00; opcode = 4'b0000; s = 1'b0; imm = 1'b0; rd = 4'd0;
    cond = 4'b1110;
  endtask

  logic [3:0] ar_op  [11] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
                              4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
  logic [3:0] ar_cmd [11] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                              4'b0110, 4'b0111, 4'b1000, 4'b0100, 4'b0110};
  logic       ar_wb  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  // Condition vectors: {status, cond, pass}
  logic [3:0] cv_st [9] = '{4'b1001, 4'b1001, 4'b0010, 4'b0110, 4'b0110,
                            4'b0000, 4'b1000, 4'b0000, 4'b1111};
  logic [3:0] cv_cd [9] = '{4'b1010, 4'b1011, 4'b1000, 4'b1000, 4'b1001,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110};
  logic       cv_ok [9] = '{1, 0, 1, 0, 1, 1, 1, 0, 1};

  initial begin
    rst_n = 1'b0; hazard = 1'b0; flush = 1'b0; freeze = 1'b0; status = 4'b0000;
    idle();
    step(); step();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_ex_cmd", ex_cmd, 0);
    rst_n = 1'b1;

    // ADD r3, S=1
    put(2'b00, 4'b0100, 1'b1, 1'b0, 4'd3);
    step();
    check("add_ex_valid", ex_valid, 1);
    check("add_ex_cmd", ex_cmd, 4'b0010);
    check("add_ex_wb", ex_wb_en, 1);
    check("add_ex_swe", ex_status_we, 1);
    check("add_ex_rd", ex_rd, 3);
    idle(); step();
    check("add_mem_wb", mem_wb_en, 1);
    check("add_mem_rd", mem_rd, 3);
    check("idle_ex_valid", ex_valid, 0);
    step();
    check("add_wb_en", wb_en, 1);
    check("add_wb_rd", wb_rd, 3);
    check("add_wb_m2r", wb_mem_to_reg, 0);

    // LDR r5
    put(2'b01, 4'b0100, 1'b1, 1'b0, 4'd5);
    step();
    check("ldr_ex_rd", ex_mem_read, 1);
    check("ldr_ex_cmd", ex_cmd, 4'b0010);
    check("ldr_ex_imm", ex_imm, 1);
    check("ldr_ex_wb", ex_wb_en, 1);
    check("ldr_ex_wr", ex_mem_write, 0);
    idle(); step(); step();
    check("ldr_wb_m2r", wb_mem_to_reg, 1);
    check("ldr_wb_rd", wb_rd, 5);
    check("ldr_wb_en", wb_en, 1);

    // STR r6
    put(2'b01, 4'b0100, 1'b0, 1'b0, 4'd6);
    step();
    check("str_ex_wr", ex_mem_write, 1);
    check("str_ex_wb", ex_wb_en, 0);
    check("str_ex_rd", ex_mem_read, 0);
    idle(); step();
    check("str_mem_wr", mem_write, 1);
    check("str_mem_wb", mem_wb_en, 0);
    step();
    check("str_wb_valid", wb_valid, 1);
    check("str_wb_en", wb_en, 0);
    check("str_wb_m2r", wb_mem_to_reg, 0);

    // Arithmetic opcode table (S=0, I=1)
    for (int i = 0; i < 11; i++) begin
      put(2'b00, ar_op[i], 1'b0, 1'b1, 4'd9);
      step();
      check("ar_cmd", {28'd0, ex_cmd}, {28'd0, ar_cmd[i]});
      check("ar_wb", ex_wb_en, ar_wb[i]);
      check("ar_imm", ex_imm, 1);
      check("ar_swe", ex_status_we, 0);
    end
    // CMP with S=1 writes flags only
    put(2'b00, 4'b1010, 1'b1, 1'b0, 4'd1);
    step();
    check("cmp_swe", ex_status_we, 1);
    check("cmp_wb", ex_wb_en, 0);

    // No-op encodings keep valid but clear control
    put(2'b00, 4'b0011, 1'b1, 1'b1, 4'd2);
    step();
    check("nop_ar_valid", ex_valid, 1);
    check("nop_ar_ctrl", {ex_cmd, ex_wb_en, ex_status_we, ex_imm}, 0);
    put(2'b11, 4'b0100, 1'b1, 1'b1, 4'd2);
    step();
    check("nop_m3_valid", ex_valid, 1);
    check("nop_m3_ctrl", {ex_cmd, ex_wb_en, ex_status_we, ex_imm, ex_branch}, 0);
    put(2'b01, 4'b0000, 1'b1, 1'b0, 4'd2);
    step();
    check("nop_mem_ctrl", {ex_cmd, ex_mem_read, ex_wb_en, ex_imm}, 0);

    // Hazard: SUB r2 goes ahead, ADD r3 is bubbled
    put(2'b00, 4'b0010, 1'b0, 1'b0, 4'd2);
    step();
    put(2'b00, 4'b0100, 1'b1, 1'b0, 4'd3);
    hazard = 1'b1;
    step();
    check("hz_ex_valid", ex_valid, 0);
    check("hz_ex_ctrl", {ex_cmd, ex_wb_en, ex_status_we, ex_rd}, 0);
    check("hz_mem_valid", mem_valid, 1);
    check("hz_mem_rd", mem_rd, 2);
    check("hz_mem_wb", mem_wb_en, 1);
    flush = 1'b1;
    step();
    check("hzfl_ex_valid", ex_valid, 0);
    hazard = 1'b0; flush = 1'b0;

    // Branch then flush: the branch itself advances
    put(2'b10, 4'b0000, 1'b1, 1'b1, 4'd7);
    step();
    check("br_ex_branch", ex_branch, 1);
    check("br_ex_ctrl", {ex_cmd, ex_wb_en, ex_imm, ex_status_we}, 0);
    put(2'b00, 4'b0100, 1'b0, 1'b0, 4'd4);
    flush = 1'b1;
    step();
    check("fl_ex_valid", ex_valid, 0);
    check("fl_mem_valid", mem_valid, 1);
    check("fl_mem_rd", mem_rd, 7);
    flush = 1'b0;

    // Freeze with A/B/C in WB/MEM/EX
    put(2'b00, 4'b0100, 1'b0, 1'b0, 4'd1); step();
    put(2'b00, 4'b0010, 1'b0, 1'b0, 4'd2); step();
    put(2'b00, 4'b0001, 1'b0, 1'b0, 4'd3); step();
    put(2'b00, 4'b1100, 1'b0, 1'b0, 4'd4);
    freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("frz_ex_rd", ex_rd, 3);
      check("frz_ex_cmd", ex_cmd, 4'b1000);
      check("frz_mem_rd", mem_rd, 2);
      check("frz_wb_rd", wb_rd, 1);
    end
    freeze = 1'b0;
    step();
    check("res_ex_rd", ex_rd, 4);
    check("res_ex_cmd", ex_cmd, 4'b0111);
    check("res_mem_rd", mem_rd, 3);
    check("res_wb_rd", wb_rd, 2);

    // Condition EQ with Z=0, then Z=1
    put(2'b00, 4'b0100, 1'b0, 1'b0, 4'd7);
    cond = 4'b0000; status = 4'b0000;
    #1;
    check("eq_z0_pass", id_cond_pass, CC ? 0 : 1);
    step();
    check("eq_z0_ex_valid", ex_valid, CC ? 0 : 1);
    status = 4'b0100;
    #1;
    check("eq_z1_pass", id_cond_pass, 1);
    step();
    check("eq_z1_ex_valid", ex_valid, 1);
    check("eq_z1_ex_rd", ex_rd, 7);

    idle();
    for (int i = 0; i < 9; i++) begin
      status = cv_st[i]; cond = cv_cd[i];
      #1;
      check("cond_tbl", id_cond_pass, CC ? cv_ok[i] : 1'b1);
    end
    status = 4'b0000;

    // Reset with a pipeline full of stores
    for (int i = 1; i <= 3; i++) begin
      put(2'b01, 4'b0100, 1'b0, 1'b0, 4'(i));
      step();
    end
    check("pre_rst_mem_wr", mem_write, 1);
    rst_n = 1'b0;
    step();
    check("mrst_valid", {ex_valid, mem_valid, wb_valid}, 0);
    check("mrst_wr", {ex_mem_write, mem_write}, 0);
    check("mrst_wb", {ex_wb_en, mem_wb_en, wb_en}, 0);
    rst_n = 1'b1;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_pipelined_control_unit
`default_nettype wire
